// File: rtl/systolic_feeder.sv
// systolic_feeder: upstream feeder of the systolic array.
// Loads DEPTH weight rows (one per cycle, control=1), then streams data rows
// through a diagonal skew (lane k delayed k+1 cycles), drains the skew with
// zeros and pulses done during the final drain cycle.
// Optional build macro: FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt
// output that counts STREAM cycles with no row offered.
module systolic_feeder #(
   parameter int DEPTH     = 4,
   parameter int BIT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [BIT_WIDTH*DEPTH-1:0] wt_in,
   input  logic                       wt_valid,
   output logic                       wt_ready,
   input  logic [BIT_WIDTH*DEPTH-1:0] row_in,
   input  logic                       row_valid,
   input  logic                       row_last,
   output logic                       row_ready,
   output logic                       control,
   output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
   output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
   output logic                       busy,
   output logic                       done
`ifdef FEEDER_BUBBLE_CNT_EN
   ,
   output logic [15:0]                bubble_cnt
`endif
);

   localparam int                CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_WT = 2'd1,
      STREAM  = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             wt_cnt_q, wt_cnt_d;
   logic [CNT_W-1:0]             drain_cnt_q, drain_cnt_d;
   logic                         done_d;
   logic                         skew_clr;
   logic                         skew_adv;
   logic                         wt_fire;
   logic [BIT_WIDTH*DEPTH-1:0]   x_row;

   // State and counter registers.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wt_cnt_q    <= '0;
         drain_cnt_q <= '0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         wt_cnt_q    <= wt_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         done        <= done_d;
      end
   end

   // Next-state, handshake and skew-stage-input decode.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      wt_cnt_d    = wt_cnt_q;
      drain_cnt_d = drain_cnt_q;
      wt_ready    = 1'b0;
      row_ready   = 1'b0;
      skew_clr    = 1'b0;
      skew_adv    = 1'b0;
      x_row       = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD_WT;
               wt_cnt_d = '0;
               skew_clr = 1'b1;
            end
         end
         LOAD_WT: begin
            wt_ready = 1'b1;
            if (wt_valid) begin
               wt_cnt_d = wt_cnt_q + CNT_W'(1);
               if (wt_cnt_q == LAST) state_d = STREAM;
            end
         end
         STREAM: begin
            row_ready = 1'b1;
            skew_adv  = 1'b1;
            if (row_valid) begin
               x_row = row_in;
               if (row_last) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            skew_adv    = 1'b1;
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
            if (drain_cnt_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // done is registered so that it is high during the last DRAIN cycle.
      done_d = (state_d == DRAIN) && (drain_cnt_d == LAST);
   end

   assign busy    = (state_q != IDLE);
   assign wt_fire = wt_ready & wt_valid;

   // Weight output register: one-cycle pulse of control with the fired row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         control <= 1'b0;
         wt_arr  <= '0;
      end else begin
         control <= wt_fire;
         if (wt_fire) wt_arr <= wt_in;
      end
   end

   // Diagonal skew: lane k is a (k+1)-deep shift chain.
   for (genvar k = 0; k < DEPTH; k++) begin : g_lane
      logic [BIT_WIDTH-1:0] pipe [k+1];

      // Lane k shift chain; cleared on job start, advances in STREAM/DRAIN.
      // NOTE: these chains are small flop arrays, not RAM, and must read as
      // zero straight after reset, so they take the asynchronous reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j <= k; j++) pipe[j] <= '0;
         end else if (skew_clr) begin
            for (int j = 0; j <= k; j++) pipe[j] <= '0;
         end else if (skew_adv) begin
            pipe[0] <= x_row[k*BIT_WIDTH +: BIT_WIDTH];
            for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
         end
      end

      assign data_arr[k*BIT_WIDTH +: BIT_WIDTH] = pipe[k];
   end

`ifdef FEEDER_BUBBLE_CNT_EN
   // Saturating count of STREAM cycles with no row offered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (skew_clr) begin
         bubble_cnt <= '0;
      end else if ((state_q == STREAM) && !row_valid && (bubble_cnt != 16'hFFFF)) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed testbench for systolic_feeder (DEPTH=4, BIT_WIDTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_systolic_feeder;

   localparam int DEPTH     = 4;
   localparam int BIT_WIDTH = 8;
   localparam int W         = DEPTH * BIT_WIDTH;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         start     = 1'b0;
   logic [W-1:0] wt_in     = '0;
   logic         wt_valid  = 1'b0;
   logic [W-1:0] row_in    = '0;
   logic         row_valid = 1'b0;
   logic         row_last  = 1'b0;
   logic         wt_ready, row_ready, control, busy, done;
   logic [W-1:0] wt_arr, data_arr;
`ifdef FEEDER_BUBBLE_CNT_EN
   logic [15:0]  bubble_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Per-job stimulus and hand-computed expectations.
   logic [W-1:0] wts      [DEPTH];
   logic [W-1:0] st_row   [16];
   bit           st_valid [16];
   bit           st_last  [16];
   int           st_n;
   logic [W-1:0] exp_data [16];
   int           exp_n;
   bit           poke;

   systolic_feeder #(.DEPTH(DEPTH), .BIT_WIDTH(BIT_WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .wt_in     (wt_in),
      .wt_valid  (wt_valid),
      .wt_ready  (wt_ready),
      .row_in    (row_in),
      .row_valid (row_valid),
      .row_last  (row_last),
      .row_ready (row_ready),
      .control   (control),
      .wt_arr    (wt_arr),
      .data_arr  (data_arr),
      .busy      (busy),
      .done      (done)
`ifdef FEEDER_BUBBLE_CNT_EN
      ,
      .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a job and push the DEPTH weight rows in wts[] back to back.
   task automatic load_weights();
      n_checks++;
      if (busy !== 1'b0 || control !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_start: busy=%b control=%b, want 0 0", busy, control);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (wt_ready !== 1'b1 || busy !== 1'b1 || row_ready !== 1'b0 || control !== 1'b0) begin
         n_fail++;
         $display("FAIL load_enter: wt_ready=%b busy=%b row_ready=%b control=%b, want 1 1 0 0",
                  wt_ready, busy, row_ready, control);
      end
      for (int i = 0; i < DEPTH; i++) begin
         wt_valid = 1'b1;
         wt_in    = wts[i];
         tick();
         n_checks++;
         if (control !== 1'b1 || wt_arr !== wts[i]) begin
            n_fail++;
            $display("FAIL wt_row%0d: control=%b wt_arr=%h, want 1 %h", i, control, wt_arr, wts[i]);
         end
      end
      wt_valid = 1'b0;
      wt_in    = '0;
      n_checks++;
      if (wt_ready !== 1'b0 || row_ready !== 1'b1 || data_arr !== '0) begin
         n_fail++;
         $display("FAIL stream_enter: wt_ready=%b row_ready=%b data_arr=%h, want 0 1 0",
                  wt_ready, row_ready, data_arr);
      end
   endtask

   // Drive st_* from the first STREAM cycle through drain to IDLE, checking
   // data_arr against both the hand table and a per-lane delay model.
   task automatic run_stream(input string name);
      logic [W-1:0] xh [$];
      logic [W-1:0] x, model, past;
      int           f;
      int           s;
      bit           ended;
      f     = -1;
      ended = 1'b0;
      for (int m = 0; m < st_n + DEPTH + 1 && !ended; m++) begin
         if (f < 0 && m < st_n) begin
            row_in    = st_row[m];
            row_valid = st_valid[m];
            row_last  = st_last[m];
            x         = st_valid[m] ? st_row[m] : '0;
            if (st_valid[m] && st_last[m]) f = m;
         end else begin
            row_in    = '0;
            row_valid = 1'b0;
            row_last  = 1'b0;
            x         = '0;
         end
         start    = poke;
         wt_valid = poke;
         wt_in    = {W{1'b1}};
         tick();
         xh.push_back(x);
         model = '0;
         for (int k = 0; k < DEPTH; k++) begin
            if (xh.size() > k) begin
               past = xh[xh.size() - 1 - k];
               model[k*BIT_WIDTH +: BIT_WIDTH] = past[k*BIT_WIDTH +: BIT_WIDTH];
            end
         end
         s = (f < 0) ? -1 : m - f;
         n_checks++;
         if (data_arr !== model) begin
            n_fail++;
            $display("FAIL %s model c%0d: data_arr=%h, want %h", name, m, data_arr, model);
         end
         if (m < exp_n) begin
            n_checks++;
            if (data_arr !== exp_data[m]) begin
               n_fail++;
               $display("FAIL %s table c%0d: data_arr=%h, want %h", name, m, data_arr, exp_data[m]);
            end
         end
         n_checks++;
         if (done !== (s == DEPTH - 1) || busy !== (s < DEPTH) || row_ready !== (s < 0)
             || control !== 1'b0 || wt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctrl c%0d: done=%b busy=%b row_ready=%b control=%b wt_ready=%b, want %b %b %b 0 0",
                     name, m, done, busy, row_ready, control, wt_ready,
                     (s == DEPTH - 1), (s < DEPTH), (s < 0));
         end
         if (s == DEPTH) ended = 1'b1;
      end
      start    = 1'b0;
      wt_valid = 1'b0;
      wt_in    = '0;
      n_checks++;
      if (!ended) begin
         n_fail++;
         $display("FAIL %s job_end: job did not return to IDLE within %0d cycles, want 1", name, st_n + DEPTH + 1);
      end
   endtask

   task automatic single_row_job(input logic [W-1:0] r);
      st_n = 1;
      st_row[0] = r; st_valid[0] = 1'b1; st_last[0] = 1'b1;
      exp_n = 5;
      exp_data[0] = {24'h0, r[7:0]};
      exp_data[1] = {16'h0, r[15:8], 8'h0};
      exp_data[2] = {8'h0, r[23:16], 16'h0};
      exp_data[3] = {r[31:24], 24'h0};
      exp_data[4] = '0;
   endtask

   task automatic test_reset();
      n_checks++;
      if (control !== 0 || wt_arr !== '0 || data_arr !== '0 || busy !== 0 || done !== 0
          || wt_ready !== 0 || row_ready !== 0) begin
         n_fail++;
         $display("FAIL reset: control=%b wt_arr=%h data_arr=%h busy=%b done=%b wt_ready=%b row_ready=%b, want all 0",
                  control, wt_arr, data_arr, busy, done, wt_ready, row_ready);
      end
`ifdef FEEDER_BUBBLE_CNT_EN
      n_checks++;
      if (bubble_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_bubble: bubble_cnt=%0d, want 0", bubble_cnt);
      end
`endif
   endtask

   // Weight order 1, 0x100, 0x10000, 0x1000000, then the single-row skew.
   task automatic test_weight_load_single_row();
      wts[0] = 32'h00000001; wts[1] = 32'h00000100;
      wts[2] = 32'h00010000; wts[3] = 32'h01000000;
      load_weights();
      single_row_job(32'h04030201);
      run_stream("single_row");
      n_checks++;
      if (wt_arr !== 32'h01000000) begin
         n_fail++;
         $display("FAIL wt_hold: wt_arr=%h, want 01000000", wt_arr);
      end
   endtask

   task automatic test_back_to_back();
      wts[0] = 32'h11111111; wts[1] = 32'h22222222;
      wts[2] = 32'h33333333; wts[3] = 32'h44444444;
      load_weights();
      st_n = 3;
      st_row[0] = 32'h00000001; st_valid[0] = 1; st_last[0] = 0;
      st_row[1] = 32'h00000102; st_valid[1] = 1; st_last[1] = 0;
      st_row[2] = 32'h00010201; st_valid[2] = 1; st_last[2] = 1;
      exp_n = 7;
      exp_data[0] = 32'h00000001; exp_data[1] = 32'h00000002;
      exp_data[2] = 32'h00000101; exp_data[3] = 32'h00000200;
      exp_data[4] = 32'h00010000; exp_data[5] = 32'h00000000;
      exp_data[6] = 32'h00000000;
      run_stream("back_to_back");
   endtask

   task automatic test_bubbles();
      load_weights();
      st_n = 4;
      st_row[0] = 32'h04030201; st_valid[0] = 1; st_last[0] = 0;
      st_row[1] = 32'hDEADBEEF; st_valid[1] = 0; st_last[1] = 0;
      st_row[2] = 32'hDEADBEEF; st_valid[2] = 0; st_last[2] = 1;
      st_row[3] = 32'h08070605; st_valid[3] = 1; st_last[3] = 1;
      exp_n = 8;
      exp_data[0] = 32'h00000001; exp_data[1] = 32'h00000200;
      exp_data[2] = 32'h00030000; exp_data[3] = 32'h04000005;
      exp_data[4] = 32'h00000600; exp_data[5] = 32'h00070000;
      exp_data[6] = 32'h08000000; exp_data[7] = 32'h00000000;
      run_stream("bubbles");
`ifdef FEEDER_BUBBLE_CNT_EN
      n_checks++;
      if (bubble_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL bubble_cnt_done: bubble_cnt=%0d, want 2", bubble_cnt);
      end
      tick();
      n_checks++;
      if (bubble_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL bubble_cnt_hold: bubble_cnt=%0d, want 2", bubble_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid_stream();
      load_weights();
      row_valid = 1'b1; row_last = 1'b0;
      row_in = 32'h04030201; tick();
      row_in = 32'h08070605; tick();
      n_checks++;
      if (data_arr !== 32'h00000205 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: data_arr=%h busy=%b, want 00000205 1", data_arr, busy);
      end
      row_valid = 1'b0;
      row_in    = '0;
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      #2 rst_n = 1'b1;
      tick();
      wts[0] = 32'hA0A0A0A0; wts[1] = 32'hB1B1B1B1;
      wts[2] = 32'hC2C2C2C2; wts[3] = 32'hD3D3D3D3;
      load_weights();
      single_row_job(32'h55AA33CC);
      run_stream("after_reset");
   endtask

   task automatic test_ignore_start();
      load_weights();
      poke = 1'b1;
      single_row_job(32'h0A0B0C0D);
      run_stream("ignore_start");
      poke = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || wt_ready !== 1'b0 || control !== 1'b0 || wt_arr !== wts[DEPTH-1]) begin
         n_fail++;
         $display("FAIL ignore_start_idle: busy=%b wt_ready=%b control=%b wt_arr=%h, want 0 0 0 %h",
                  busy, wt_ready, control, wt_arr, wts[DEPTH-1]);
      end
`ifdef FEEDER_BUBBLE_CNT_EN
      n_checks++;
      if (bubble_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL ignore_start_bubble: bubble_cnt=%0d, want 0", bubble_cnt);
      end
`endif
   endtask

   initial begin
      poke = 1'b0;
      #3;
      test_reset();
      #9 rst_n = 1'b1;
      tick();
      test_weight_load_single_row();
      test_back_to_back();
      test_bubbles();
      test_reset_mid_stream();
      test_ignore_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
